// File: rtl/brg_sram_word_seq.sv
`default_nettype none
// ============================================================================
//  Module      : brg_sram_word_seq
//  Description : Sequences 32-bit word requests onto a byte-wide SRAM, one
//                byte lane per cycle in ascending lane order. Reads assemble
//                the four returned bytes into a word. Writes report data 0.
//                Optional feature macro: BRG_SRAM_WORD_SEQ_WRITE_MASK_EN.
//                When it is defined, write lanes whose mask bit is 0 are
//                skipped. When it is undefined, every write covers all four
//                lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module brg_sram_word_seq #(
  parameter int word_addr_width_p  = 8,
  parameter int sram_addr_width_lp = word_addr_width_p + 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic                          w_i,
  input  logic [word_addr_width_p-1:0]  addr_i,
  input  logic [31:0]                   data_i,
  input  logic [3:0]                    mask_i,
  output logic                          v_o,
  output logic [31:0]                   data_o,
  input  logic                          yumi_i,
  output logic                          sram_v_o,
  output logic                          sram_w_o,
  output logic [sram_addr_width_lp-1:0] sram_addr_o,
  output logic [7:0]                    sram_data_o,
  input  logic [7:0]                    sram_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic                           w_q, w_d;
  logic [word_addr_width_p-1:0]   addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [31:0]                    word_q, word_d;
  // Lanes still to be issued for the current request, one bit per lane.
  logic [3:0]                     rem_q, rem_d;
  // Lane whose read byte arrives in the current cycle (valid when cap_q).
  logic [1:0]                     lane_q, lane_d;
  logic                           cap_q, cap_d;

  logic [3:0]                     mask_eff;
  logic [3:0]                     rem_next;
  logic [1:0]                     cur_lane;
  logic                           issue;
  logic                           accept;

`ifdef BRG_SRAM_WORD_SEQ_WRITE_MASK_EN
  assign mask_eff = mask_i;
`else
  logic unused_mask;
  assign unused_mask = ^mask_i;
  assign mask_eff    = 4'hF;
`endif

  assign ready_o = (state_q == IDLE) && !reset_i;
  assign accept  = v_i && ready_o;
  // A lane goes out every ACCESS cycle that still has lanes left. The final
  // ACCESS cycle of a read has none left and only captures the last byte.
  assign issue   = (state_q == ACCESS) && (rem_q != 4'b0000) && !reset_i;

  // Lowest pending lane, so lanes go out in ascending order and masked lanes cost no cycle
  always_comb begin
    cur_lane = 2'd3;
    if (rem_q[0])      cur_lane = 2'd0;
    else if (rem_q[1]) cur_lane = 2'd1;
    else if (rem_q[2]) cur_lane = 2'd2;
  end

  assign rem_next    = rem_q & ~(4'b0001 << cur_lane);

  assign sram_v_o    = issue;
  assign sram_w_o    = issue && w_q;
  assign sram_addr_o = sram_addr_width_lp'({addr_q, cur_lane});
  assign sram_data_o = wdata_q[8*cur_lane +: 8];

  assign v_o         = (state_q == RESP) && !reset_i;
  assign data_o      = v_o ? word_q : 32'h0;

  // Next-state, request capture, byte assembly and lane bookkeeping
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    cap_d   = 1'b0;

    // The SRAM returns read data one cycle after issue; land it in its lane.
    if (cap_q) begin
      word_d[8*lane_q +: 8] = sram_data_i;
    end

    case (state_q)
      IDLE: begin
        lane_d = 2'd0;
        if (accept) begin
          w_d     = w_i;
          addr_d  = addr_i;
          wdata_d = data_i;
          word_d  = 32'h0;
          rem_d   = w_i ? mask_eff : 4'hF;
          // A write with no enabled lanes has nothing to do on the SRAM.
          state_d = (w_i && (mask_eff == 4'b0000)) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (issue) begin
          rem_d  = rem_next;
          lane_d = cur_lane;
          cap_d  = !w_q;
          if (w_q && (rem_next == 4'b0000)) begin
            state_d = RESP;
          end
        end else begin
          // Read drain: the last lane's byte is captured in this cycle.
          state_d = RESP;
        end
      end
      RESP: begin
        if (yumi_i) begin
          state_d = IDLE;
          lane_d  = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      w_q     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rem_q   <= 4'b0000;
      lane_q  <= 2'd0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      cap_q   <= cap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_brg_sram_word_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brg_sram_word_seq
//  Description : Self-checking bench for brg_sram_word_seq. Each request is
//                expanded into the exact cycle-by-cycle trace that the word
//                sequencing rules imply. A single negedge process compares
//                the DUT against that trace. A byte-array SRAM model serves
//                the DUT, and a separate reference memory predicts read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brg_sram_word_seq;

`ifdef BRG_SRAM_WORD_SEQ_WRITE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i, v_i, w_i, yumi_i;
  logic [7:0]  addr_i;
  logic [31:0] data_i;
  logic [3:0]  mask_i;
  logic        ready_o, v_o, sram_v_o, sram_w_o;
  logic [31:0] data_o;
  logic [9:0]  sram_addr_o;
  logic [7:0]  sram_data_o;
  logic [7:0]  sram_data_i = 8'h00;

  always #5 clk_i = ~clk_i;

  brg_sram_word_seq #(.word_addr_width_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i), .sram_v_o(sram_v_o), .sram_w_o(sram_w_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i)
  );

  typedef struct {
    bit          rst, v_i, w_i, yumi;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    bit          e_ready, e_sv, e_sw, e_vo;
    logic [9:0]  e_addr;
    logic [7:0]  e_sdata;
    logic [31:0] e_do;
  } cyc_t;

  cyc_t        trace_q[$];
  cyc_t        cur;
  bit          cur_v = 1'b0;
  logic [7:0]  mem [1024];
  logic [7:0]  ref_mem [1024];
  bit          mem_init = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] last_resp = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.v_i = 0; c.w_i = 0; c.yumi = 0; c.addr = 0; c.data = 0; c.mask = 0;
    c.e_ready = 0; c.e_sv = 0; c.e_sw = 0; c.e_vo = 0; c.e_addr = 0; c.e_sdata = 0;
    c.e_do = 0;
    return c;
  endfunction

  // Busy cycle: random request inputs that the DUT must ignore.
  function automatic cyc_t busy();
    cyc_t c = blank();
    c.v_i  = 1'($urandom_range(0, 1));
    c.w_i  = 1'($urandom_range(0, 1));
    c.addr = 8'($urandom);
    c.data = $urandom;
    c.mask = 4'($urandom);
    return c;
  endfunction

  task automatic push_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.e_ready = 1;
      trace_q.push_back(c);
    end
  endtask

  task automatic push_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = busy();
      c.rst = 1;
      trace_q.push_back(c);
    end
  endtask

  // Expand one request into its full cycle trace. rst_at2 replaces the
  // T+2 cycle with a reset pulse (the request then yields no response).
  task automatic push_txn(input bit w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int hold, input bit rst_at2);
    cyc_t       c;
    logic [3:0] lanes;
    int         n = 0;
    c = blank();
    c.v_i = 1; c.w_i = w; c.addr = a; c.data = d; c.mask = m; c.e_ready = 1;
    trace_q.push_back(c);
    lanes = w ? (MASK_EN ? m : 4'hF) : 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (lanes[k]) begin
        if (rst_at2 && n == 1) begin
          c = busy();
          c.rst = 1;
          trace_q.push_back(c);
          return;
        end
        c = busy();
        c.e_sv = 1; c.e_sw = w; c.e_addr = {a, 2'(k)}; c.e_sdata = d[8*k +: 8];
        trace_q.push_back(c);
        n++;
        if (w) ref_mem[{a, 2'(k)}] = d[8*k +: 8];
      end
    end
    if (!w) trace_q.push_back(busy());
    for (int h = 0; h <= hold; h++) begin
      c = busy();
      c.yumi = (h == hold);
      c.e_vo = 1;
      c.e_do = w ? 32'h0 : {ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}],
                            ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]};
      trace_q.push_back(c);
    end
  endtask

  task automatic run();
    int i;
    for (i = 0; i < 5000 && trace_q.size() != 0; i++) @(posedge clk_i);
    if (trace_q.size() != 0) chk("trace_drain_timeout", 32'(trace_q.size()), 32'h0);
    repeat (2) @(negedge clk_i);
  endtask

  // Byte SRAM model: one-cycle read latency, junk on the data bus otherwise
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1'b1;
    end else if (sram_v_o) begin
      acc_cnt <= acc_cnt + 1;
      if (sram_w_o) mem[sram_addr_o] <= sram_data_o;
      else          sram_data_i      <= mem[sram_addr_o];
    end else begin
      sram_data_i <= 8'($urandom);
    end
    if (v_o) last_resp <= data_o;
  end

  // Stimulus engine: one trace record per cycle, driven just after the edge
  initial begin
    reset_i = 1; v_i = 0; w_i = 0; yumi_i = 0; addr_i = 0; data_i = 0; mask_i = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (trace_q.size() > 0) begin
        cur   = trace_q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur   = blank();
        cur_v = 1'b0;
      end
      reset_i = cur.rst; v_i = cur.v_i; w_i = cur.w_i; addr_i = cur.addr;
      data_i = cur.data; mask_i = cur.mask; yumi_i = cur.yumi;
    end
  end

  // Compare process: DUT outputs against the expected trace every cycle
  always @(negedge clk_i) begin
    if (cur_v) begin
      chk("ready_o", 32'(ready_o), 32'(cur.e_ready));
      chk("sram_v_o", 32'(sram_v_o), 32'(cur.e_sv));
      chk("sram_w_o", 32'(sram_w_o), 32'(cur.e_sw));
      if (cur.e_sv) chk("sram_addr_o", 32'(sram_addr_o), 32'(cur.e_addr));
      if (cur.e_sv && cur.e_sw) chk("sram_data_o", 32'(sram_data_o), 32'(cur.e_sdata));
      chk("v_o", 32'(v_o), 32'(cur.e_vo));
      if (cur.e_vo || cur.rst) chk("data_o", data_o, cur.e_do);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a0;
    bit         w;
    logic [7:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);

    // Reset state, then idle with ready high.
    push_reset(3);
    push_idle(2);
    run();

    // Full-word write to word 5.
    a0 = acc_cnt;
    push_txn(1, 8'h05, 32'hDEADBEEF, 4'hF, 0, 0);
    run();
    chk("wr05_byte014", 32'(mem[10'h014]), 32'h0000_00EF);
    chk("wr05_byte015", 32'(mem[10'h015]), 32'h0000_00BE);
    chk("wr05_byte016", 32'(mem[10'h016]), 32'h0000_00AD);
    chk("wr05_byte017", 32'(mem[10'h017]), 32'h0000_00DE);
    chk("wr05_access_count", 32'(acc_cnt - a0), 32'd4);

    // Read back word 5.
    a0 = acc_cnt;
    push_txn(0, 8'h05, 32'h0, 4'h0, 0, 0);
    run();
    chk("rd05_data", last_resp, 32'hDEADBEEF);
    chk("rd05_access_count", 32'(acc_cnt - a0), 32'd4);

    // Response held ten cycles with garbage requests arriving.
    push_idle(1);
    push_txn(0, 8'h05, 32'h0, 4'h0, 10, 0);
    push_idle(1);
    run();

`ifdef BRG_SRAM_WORD_SEQ_WRITE_MASK_EN
    a0 = acc_cnt;
    push_txn(1, 8'hFF, 32'h11223344, 4'b1010, 0, 0);
    run();
    chk("mask1010_byte3FD", 32'(mem[10'h3FD]), 32'h0000_0033);
    chk("mask1010_byte3FF", 32'(mem[10'h3FF]), 32'h0000_0011);
    chk("mask1010_byte3FC", 32'(mem[10'h3FC]), 32'(8'(10'h3FC * 7 + 3)));
    chk("mask1010_access_count", 32'(acc_cnt - a0), 32'd2);
    a0 = acc_cnt;
    push_txn(1, 8'h10, 32'hCAFEF00D, 4'b0000, 0, 0);
    run();
    chk("mask0000_access_count", 32'(acc_cnt - a0), 32'd0);
`else
    a0 = acc_cnt;
    push_txn(1, 8'h00, 32'hA5A5A5A5, 4'b0001, 0, 0);
    run();
    chk("nomask_byte000", 32'(mem[10'h000]), 32'h0000_00A5);
    chk("nomask_byte003", 32'(mem[10'h003]), 32'h0000_00A5);
    chk("nomask_access_count", 32'(acc_cnt - a0), 32'd4);
`endif

    // Reset in T+2 of a read, then a clean read of the same word.
    push_txn(0, 8'h05, 32'h0, 4'h0, 0, 1);
    push_idle(1);
    push_txn(0, 8'h05, 32'h0, 4'h0, 1, 0);
    run();
    chk("rd05_after_reset", last_resp, 32'hDEADBEEF);

    // Randomized traffic over a small address window for read-after-write hits.
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? {5'h1F, 3'($urandom)} : {5'h00, 3'($urandom)};
      push_txn(w, a, $urandom, 4'($urandom), $urandom_range(0, 3), 0);
      push_idle($urandom_range(0, 2));
    end
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/brg_sram_word_seq.md
BRG_SRAM_WORD_SEQ -- requirements
Module: brg_sram_word_seq

Interface
REQ-001 SHALL have parameter word_addr_width_p, default 8, word address width (256 words of 32 bits over a 1024x8 SRAM).
REQ-002 SHALL have parameter sram_addr_width_lp, default word_addr_width_p+2, byte address width driven to the SRAM.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port v_i  input  1  request valid.
REQ-006 SHALL have port ready_o  output  1  request accepted when v_i & ready_o.
REQ-007 SHALL have port w_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr_i  input  word_addr_width_p  word address.
REQ-009 SHALL have port data_i  input  32  write data, byte k = data_i[8k+7:8k].
REQ-010 SHALL have port mask_i  input  4  per-byte write enable.
REQ-011 SHALL have port v_o  output  1  response valid.
REQ-012 SHALL have port data_o  output  32  read data; 0 for write responses.
REQ-013 SHALL have port yumi_i  input  1  response consumed; legal only when v_o=1.
REQ-014 SHALL have port sram_v_o  output  1  drives the byte SRAM v_i.
REQ-015 SHALL have port sram_w_o  output  1  drives the byte SRAM w_i.
REQ-016 SHALL have port sram_addr_o  output  sram_addr_width_lp  byte address {word addr, k}.
REQ-017 SHALL have port sram_data_o  output  8  byte write data.
REQ-018 SHALL have port sram_data_i  input  8  byte SRAM read data, valid the cycle after a read issue.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; ready_o=1 only in IDLE.
REQ-020 SHALL, on accept in cycle T, register w_i, addr_i, data_i, mask_i and enter ACCESS in T+1.
REQ-021 SHALL, in ACCESS, issue one byte access per cycle, lanes k in ascending order, with sram_v_o=1, sram_w_o=stored w, sram_addr_o={addr,k[1:0]}, sram_data_o=byte k.
REQ-022 SHALL, for reads, issue all 4 lanes in T+1..T+4, capture sram_data_i into lane k in the cycle after lane k's issue (T+2..T+5), and enter RESP in T+6 with v_o=1.
REQ-023 SHALL, for writes, skip lanes with mask bit 0 (no SRAM access), enter RESP in the cycle after the last issued lane, and report data_o=0.
REQ-024 SHALL, for a write with mask_i=4'b0000, perform no SRAM access and enter RESP in T+1.
REQ-025 SHALL hold v_o and data_o stable in RESP until yumi_i=1, then enter IDLE the next cycle; no new request accepted in the yumi cycle.
REQ-026 SHALL drive sram_v_o=0 and sram_w_o=0 in IDLE and RESP; sram_addr_o/sram_data_o are don't-care when sram_v_o=0.
REQ-027 SHALL ignore mask_i for reads and ignore sram_data_i except in capture cycles.
REQ-028 SHALL ignore v_i while ready_o=0; a 2-bit lane counter SHALL wrap only on return to IDLE.

Reset
REQ-029 SHALL, while reset_i=1, force state IDLE, lane counter 0, captured word 0; outputs v_o=0, data_o=0, sram_v_o=0, sram_w_o=0, ready_o=0.
REQ-030 SHALL, on reset mid-ACCESS, issue no further SRAM accesses from the cycle after reset is sampled, discard partial data and produce no response; ready_o=1 in the first cycle after reset_i falls.

Configuration
REQ-031 SHALL, with macro BRG_SRAM_WORD_SEQ_WRITE_MASK_EN defined, honour mask_i per REQ-023/REQ-024.
REQ-032 SHALL, without BRG_SRAM_WORD_SEQ_WRITE_MASK_EN, treat every write as mask 4'b1111 (4 lanes, RESP in T+5) and leave mask_i unused.

Verification
REQ-033 SHALL cover: write addr 8'h05 data 32'hDEADBEEF mask 4'hF -> SRAM writes 0x014=EF,0x015=BE,0x016=AD,0x017=DE in T+1..T+4, v_o in T+5, data_o=0.
REQ-034 SHALL cover: read addr 8'h05 after REQ-033 -> reads 0x014..0x017 in T+1..T+4, v_o in T+6, data_o=32'hDEADBEEF.
REQ-035 SHALL cover (macro defined): write addr 8'hFF data 32'h11223344 mask 4'b1010 -> only 0x3FD=33, 0x3FF=11 written, in T+1 and T+2, v_o in T+3; mask 4'b0000 -> no access, v_o in T+1.
REQ-036 SHALL cover: yumi_i held 0 for 10 cycles in RESP -> v_o/data_o stable, ready_o=0, v_i ignored; yumi_i=1 -> ready_o=1 next cycle.
REQ-037 SHALL cover: reset_i pulsed in T+2 of a read -> sram_v_o=0 from T+3, no v_o, next read returns correct data.
REQ-038 SHALL cover (macro undefined): write mask 4'b0001 data 32'hA5A5A5A5 addr 0 -> 4 SRAM writes 0x000..0x003=A5, v_o in T+5.
